// File: rtl/rr_packet_stream_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ ready/valid streams onto one registered output.
// Latency 1 cycle accept->valid_out; 2-entry output stage absorbs two beats when ready_in is low.
module rr_packet_stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          last_out,
    output logic [ID_WIDTH-1:0]           id_out
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
    } beat_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_WIDTH'(1);
    endfunction

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0] owner, owner_nxt;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_WIDTH-1:0]  arb_idx;
    logic                 arb_found;

    logic [ID_WIDTH-1:0]   grant;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  grant_vld;
    logic                  space;
    logic                  accept;
    beat_t                 in_beat;

    beat_t prim, skid;
    logic  prim_vld, skid_vld;

    // Rotate valids so bit 0 is the rr pointer; first set bit wins.
    always_comb begin
        logic [ID_WIDTH:0] sum;
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[NUM_REQ-1:0];
        arb_idx   = rr_ptr;
        arb_found = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && valid_rot[k]) begin
                arb_found = 1'b1;
                sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
                if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                    sum = sum - (ID_WIDTH+1)'(NUM_REQ);
                end
                arb_idx = sum[ID_WIDTH-1:0];
            end
        end
    end

    assign grant     = (state == LOCKED) ? owner : arb_idx;
    assign grant_oh  = NUM_REQ'(1) << grant;
    assign grant_vld = |(req_valid & grant_oh);
    assign space     = ~skid_vld;
    assign req_ready = {NUM_REQ{~reset & space & grant_vld}} & grant_oh;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        in_beat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                in_beat.dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        in_beat.last = |(req_last & grant_oh);
        in_beat.id   = grant;
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_beat.last) begin
                        rr_ptr_nxt = next_id(grant);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = grant;
                    end
                end
                LOCKED: begin
                    if (in_beat.last) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = next_id(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Skid is only ever filled while primary is full, so an accept never finds primary empty with skid full.
    always_ff @(posedge clk) begin
        if (reset) begin
            prim     <= '0;
            skid     <= '0;
            prim_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (accept) begin
            if (!prim_vld || ready_in) begin
                prim     <= in_beat;
                prim_vld <= 1'b1;
            end else begin
                skid     <= in_beat;
                skid_vld <= 1'b1;
            end
        end else if (prim_vld && ready_in) begin
            if (skid_vld) begin
                prim     <= skid;
                skid_vld <= 1'b0;
            end else begin
                prim_vld <= 1'b0;
            end
        end
    end

    assign valid_out = prim_vld;
    assign data_out  = prim.dat;
    assign last_out  = prim.last;
    assign id_out    = prim.id;

endmodule

// File: doc/rr_packet_stream_arbiter.md
Name: rr_packet_stream_arbiter

Overview:
- Shares one ready/valid downstream channel among NUM_REQ upstream ready/valid requesters.
- Arbitration is round-robin at packet granularity, using a per-beat last flag.
- A grant is held from the first beat of a packet until its last beat is accepted.
- Output is fully registered through an internal 2-entry stage (primary + skid), so output timing is isolated and throughput is one beat per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, payload width per beat.
- ID_WIDTH, 2, width of the requester index; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- ready_in  input  1  downstream ready.
- valid_out  output  1  output beat valid.
- data_out  output  DATA_WIDTH  output payload.
- last_out  output  1  last flag of the output beat.
- id_out  output  ID_WIDTH  index of the requester that produced the output beat.

Behaviour:
- Clocking: reset is synchronous, active-high; clock is clk. All state updates on posedge clk.
- Reset values: valid_out=0, data_out=0, last_out=0, id_out=0; both stage entries empty; state=IDLE; rr pointer=0, so requester 0 has highest priority first.
- req_ready is combinational and is forced to all-zero while reset=1.
- Stage space: space = ~skid_full.
- Upstream handshake: beat accepted from requester i iff req_valid[i] & req_ready[i].
- req_ready[i] = space & (i == grant) & req_valid-qualified arbitration result. req_ready never depends on ready_in combinationally.
- State IDLE:
  - grant = first requester with req_valid set, searching cyclically from rr pointer.
  - Accept that beat the same cycle; no arbitration bubble.
  - Accepted beat with last=1: stay IDLE; pointer <= winner+1 (mod NUM_REQ).
  - Accepted beat with last=0: go to LOCKED; owner <= winner.
- State LOCKED:
  - grant = owner only; all other req_ready = 0.
  - If the owner drops req_valid mid-packet, hold the grant; the channel idles and no other requester is served.
  - Accepted beat with last=1: go to IDLE; pointer <= owner+1 (mod NUM_REQ). The next packet is arbitrated in the following cycle.
- Output stage (per beat stores {data, last, id}):
  - Accept while primary empty, or primary full and ready_in=1: write primary.
  - Accept while primary full and ready_in=0: write skid.
  - Downstream handshake (valid_out & ready_in) with no accept: skid moves to primary if full, else primary empties.
  - Simultaneous accept and downstream handshake with skid empty: primary reloads; valid_out stays 1.
- Latency and throughput: accept to valid_out is 1 cycle. Sustained 1 beat/cycle when ready_in=1.
- Stall: ready_in=0 absorbs at most 2 beats, then space=0 and every req_ready=0.
- Outputs hold stable while valid_out=1 and ready_in=0.
- Data is never dropped or duplicated. Order within a packet is preserved. Packets never interleave on the output.
- Single requester: behaves as a 2-entry pipeline slice with id_out constant.
- Reset mid-packet: the stage is flushed (in-flight beats lost), state returns to IDLE, pointer returns to 0.
- Wrap-around: pointer NUM_REQ-1 advances to 0.
- Requesters assert req_valid independently of req_ready; data and last must be held while req_valid=1 and unaccepted.

Test Plan:
1. Reset, then all four requesters present single-beat packets (last=1) with data 0xA0..0xA3, ready_in=1 -> outputs in id order 0,1,2,3 on consecutive cycles starting 1 cycle after first accept; second round also 0,1,2,3.
2. Req1 sends a 3-beat packet 0x11,0x12,0x13 (last on third) while req2 is continuously valid -> output 0x11,0x12,0x13 with id=1, then req2's beat; req2_ready=0 throughout req1's packet.
3. Req0 streams beats with ready_in held low for 4 cycles -> exactly 2 beats accepted, req_ready=0 thereafter, valid_out=1 with data_out stable. On release, all beats arrive in order with no loss or duplication.
4. LOCKED on req3, req3 drops valid for 2 cycles mid-packet while req0 is valid -> no output for those cycles, req0 not granted. Req3 resumes and completes; then pointer wraps and req0 is granted.
5. Reset asserted mid-packet with 2 beats buffered -> next cycle valid_out=0, id_out=0, req_ready=0 during reset. After release, req0 wins over simultaneous req0/req2.
6. Randomised valid, last and ready_in for 10k cycles with scoreboard -> per-requester packet contents and order preserved, no packet interleaving, no requester starved beyond NUM_REQ-1 packets.
